qpsk_demod_rx: RTL and testbench
================================

Name: qpsk_demod_rx

Overview:
- Receive-side counterpart of the TX QPSK path: hard-decision QPSK demodulator.
- Accepts signed 12-bit I/Q baseband samples on a valid/ready stream, integrates SPS samples per symbol (integrate-and-dump), slices each rail by sign and emits one 2-bit symbol {I_bit, Q_bit} on a valid/ready output stream.
- Sits between the RX sample front end and the bit sink.
- Symbol mapping matches TX levels: 12'h5a7 (+1.0) decides bit 1, 12'ha59 (-1.0) decides bit 0.

Parameters:
- SPS, 4, samples per symbol integrated before a decision; power of two, 1..16.
- DW, 12, sample width per rail, signed two's complement.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input sample valid.
- in_data  in  2*DW  {I, Q}, I in the upper DW bits, each signed.
- in_ready  out  1  block accepts a sample this cycle.
- sym_align  in  1  single-cycle pulse that restarts symbol integration (timing re-alignment).
- out_valid  out  1  decided symbol valid.
- out_data  out  2  {I_bit, Q_bit}.
- out_ready  in  1  downstream accepts the symbol.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=2'b00, accumulators=0, sample counter=0. in_ready=1 after reset.
- Handshakes: a transfer occurs on a clk edge where valid && ready. in_ready = !(out_valid && !out_ready), i.e. the input stalls only while a decided symbol is held unaccepted.
- Accumulators: acc_I and acc_Q are signed, width AW = DW + log2(SPS). Inputs are sign-extended, so there is no overflow (4 × -2048 = -8192 fits 14 bits).
- Sample counter cnt runs 0..SPS-1 and counts accepted samples only.
- On accept with cnt < SPS-1:
  - if cnt==0, acc = sample (load); otherwise acc += sample.
  - cnt++.
- On accept with cnt == SPS-1:
  - decision uses acc + sample (the final sum); bit = 0 if the sum is negative, else 1 (sum of exactly 0 decides 1).
  - out_data is registered; out_valid=1 on the next edge, so latency is 1 cycle from the last accepted sample.
  - cnt=0.
- Output register:
  - holds out_data stable while out_valid && !out_ready.
  - clears out_valid on an edge with out_ready && no new decision.
  - if out_ready is high and a new decision completes on the same edge, the register loads the new symbol and out_valid stays 1; back-to-back symbols lose no cycle.
- No sample or symbol is ever dropped: backpressure propagates entirely through in_ready.
- sym_align (has priority over counting):
  - the partial symbol is discarded and cnt is cleared.
  - if a sample is accepted on the same cycle, it becomes sample 0 of the new symbol (acc loaded, cnt=1; for SPS=1 it is decided immediately).
  - a symbol already in the output register is unaffected.
  - a pulse while in_ready=0 still clears cnt.
- SPS=1: every accepted sample produces a symbol; the counter is degenerate (always 0).
- Reset mid-symbol: partial accumulation and any pending output are discarded immediately, with no glitch on out_valid beyond the async clear.

Test Plan:
- SPS=4, out_ready=1, 4 samples {12'h5a7,12'ha59} → one symbol out_data=2'b10, out_valid high exactly 1 cycle after the 4th accept; acc_I=5788, acc_Q=-5788.
- 100 random TX-level symbols (4 identical samples each), out_ready=1 → decoded bit pairs equal the stimulus; in_ready stays high; 100 symbols are received back-to-back with no gaps.
- I samples 5a7,a59,5a7,a59 (sum 0) and Q samples 4 × 12'h800 (sum -8192) → out_data=2'b10; no overflow.
- out_ready=0 after the first symbol completes → in_ready=0 and out_data is held for 10 cycles; on release, the first symbol transfers, then the next symbol decodes correctly.
- sym_align pulsed after 2 samples of a symbol, then 4 fresh samples → exactly one symbol emitted, decided from the 4 post-align samples only; sym_align coincident with an accept → that sample counts as sample 0.
- rst asserted mid-symbol (cnt=2) and while out_valid=1 → out_valid=0 asynchronously; after release, the next 4 samples produce one correct symbol.

Source files
------------

// File: rtl/qpsk_demod_rx.sv
// Hard-decision QPSK demodulator: integrate-and-dump over SPS samples per rail,
// sign slice, and a one-deep output register with valid/ready on both sides.
module qpsk_demod_rx #(
   parameter int SPS = 4,
   parameter int DW  = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [2*DW-1:0] in_data,
   output logic            in_ready,
   input  logic            sym_align,
   output logic            out_valid,
   output logic [1:0]      out_data,
   input  logic            out_ready
);

   localparam int LG = $clog2(SPS);
   localparam int AW = DW + LG;
   localparam int CW = (LG > 0) ? LG : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);

   function automatic logic signed [AW-1:0] sext(input logic signed [DW-1:0] s);
      return AW'(s);
   endfunction

   // Zero decides 1, so only the sign bit matters.
   function automatic logic slice(input logic signed [AW-1:0] s);
      return ~s[AW-1];
   endfunction

   logic signed [DW-1:0] samp_i_p0, samp_q_p0;
   logic signed [AW-1:0] base_i_p0, base_q_p0, sum_i_p0, sum_q_p0;
   logic signed [AW-1:0] acc_i, acc_q;
   logic [CW-1:0]        cnt, cnt_eff_p0;
   logic                 accept_p0, first_p0, last_p0, decide_p0;
   logic                 vld_p1;
   logic [1:0]           sym_p1;

   // Stage p0: sample accept, integrate, decide
   assign samp_i_p0  = in_data[2*DW-1:DW];
   assign samp_q_p0  = in_data[DW-1:0];
   assign in_ready   = !(vld_p1 && !out_ready);
   assign accept_p0  = in_valid && in_ready;
   // Re-alignment takes effect on the same cycle as a coincident sample.
   assign cnt_eff_p0 = sym_align ? '0 : cnt;
   assign first_p0   = (cnt_eff_p0 == '0);
   assign last_p0    = (cnt_eff_p0 == CNT_LAST);
   assign base_i_p0  = first_p0 ? '0 : acc_i;
   assign base_q_p0  = first_p0 ? '0 : acc_q;
   assign sum_i_p0   = base_i_p0 + sext(samp_i_p0);
   assign sum_q_p0   = base_q_p0 + sext(samp_q_p0);
   assign decide_p0  = accept_p0 && last_p0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         acc_i <= '0;
         acc_q <= '0;
      end else if (accept_p0) begin
         acc_i <= sum_i_p0;
         acc_q <= sum_q_p0;
         cnt   <= last_p0 ? '0 : cnt_eff_p0 + CW'(1);
      end else if (sym_align) begin
         cnt   <= '0;
         acc_i <= '0;
         acc_q <= '0;
      end
   end

   // Stage p1: decided symbol register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         sym_p1 <= 2'b00;
      end else if (decide_p0) begin
         vld_p1 <= 1'b1;
         sym_p1 <= {slice(sum_i_p0), slice(sum_q_p0)};
      end else if (out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = sym_p1;

endmodule

// File: tb/tb_qpsk_demod_rx.sv
// Directed bench for qpsk_demod_rx (SPS=4): hand-computed symbol decisions,
// backpressure, re-alignment and asynchronous reset behaviour.
module tb_qpsk_demod_rx;

   localparam logic [11:0] P1  = 12'h5a7;
   localparam logic [11:0] M1  = 12'ha59;
   localparam logic [11:0] BIG = 12'h7ff;
   localparam logic [11:0] NEG = 12'h800;
   localparam logic [11:0] S_M = 12'hf9c;   // -100
   localparam logic [11:0] S_P = 12'h064;   // +100

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [23:0] in_data = '0;
   logic        in_ready;
   logic        sym_align = 1'b0;
   logic        out_valid;
   logic [1:0]  out_data;
   logic        out_ready = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   int stalls = 0;
   int cyc = 0;
   logic [1:0] got_q[$];
   int         stamp_q[$];
   logic [1:0] exp_q[$];

   qpsk_demod_rx #(.SPS(4), .DW(12)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .sym_align(sym_align),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && out_valid && out_ready) begin
         got_q.push_back(out_data);
         stamp_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [11:0] si, input logic [11:0] sq, input logic al);
      bit rdy;
      int n;
      in_valid  = 1'b1;
      in_data   = {si, sq};
      sym_align = al;
      n = 0;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 64);
      sym_align = 1'b0;
      if (!rdy) check("push_timeout", 0, 1);
      if (n > 1) stalls++;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int bad;
      logic bi, bq;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      idle(2);

      // single symbol, latency
      got_q.delete();
      repeat (3) push(P1, M1, 0);
      check("lat_before", out_valid, 0);
      push(P1, M1, 0);
      check("lat_valid", out_valid, 1);
      check("lat_data", out_data, 2'b10);
      check("acc_i", dut.acc_i, 5788);
      check("acc_q", dut.acc_q, -5788);
      idle(3);
      check("single_count", got_q.size(), 1);
      check("single_sym", got_q[0], 2'b10);

      // 100 back-to-back random TX-level symbols
      got_q.delete();
      stamp_q.delete();
      exp_q.delete();
      stalls = 0;
      for (int k = 0; k < 100; k++) begin
         bi = 1'($urandom_range(0, 1));
         bq = 1'($urandom_range(0, 1));
         exp_q.push_back({bi, bq});
         repeat (4) push(bi ? P1 : M1, bq ? P1 : M1, 0);
      end
      idle(3);
      check("rand_stalls", stalls, 0);
      check("rand_count", got_q.size(), 100);
      for (int k = 0; k < 100 && k < got_q.size(); k++)
         check($sformatf("rand_sym%0d", k), got_q[k], exp_q[k]);
      bad = 0;
      for (int k = 1; k < stamp_q.size(); k++)
         if (stamp_q[k] - stamp_q[k-1] != 4) bad++;
      check("rand_gaps", bad, 0);

      // zero sum on I, full-scale negative on Q
      got_q.delete();
      push(P1, NEG, 0);
      push(M1, NEG, 0);
      push(P1, NEG, 0);
      push(M1, NEG, 0);
      check("zero_acc_i", dut.acc_i, 0);
      check("zero_acc_q", dut.acc_q, -8192);
      idle(3);
      check("zero_count", got_q.size(), 1);
      check("zero_sym", got_q[0], 2'b10);

      // backpressure: hold symbol for 10 cycles
      got_q.delete();
      out_ready = 1'b0;
      repeat (4) push(M1, P1, 0);
      check("bp_valid", out_valid, 1);
      in_data = {P1, P1};
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 2'b01) bad++;
      end
      check("bp_hold", bad, 0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (4) push(P1, P1, 0);
      idle(3);
      check("bp_count", got_q.size(), 2);
      check("bp_first", got_q[0], 2'b01);
      check("bp_second", got_q[1], 2'b11);

      // sym_align between samples discards the partial symbol
      got_q.delete();
      repeat (2) push(BIG, NEG, 0);
      in_valid  = 1'b0;
      sym_align = 1'b1;
      @(posedge clk);
      #1;
      sym_align = 1'b0;
      repeat (4) push(S_M, S_P, 0);
      idle(3);
      check("align_count", got_q.size(), 1);
      check("align_sym", got_q[0], 2'b01);

      // sym_align coincident with an accept: that sample is sample 0
      got_q.delete();
      repeat (3) push(BIG, NEG, 0);
      push(S_M, S_P, 1);
      repeat (3) push(S_M, S_P, 0);
      idle(3);
      check("coal_count", got_q.size(), 1);
      check("coal_sym", got_q[0], 2'b01);

      // reset mid-symbol
      got_q.delete();
      repeat (2) push(P1, P1, 0);
      in_valid = 1'b0;
      check("mid_cnt", dut.cnt, 2);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_cnt", dut.cnt, 0);
      check("mid_rst_acc", dut.acc_i, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // reset with a pending symbol
      out_ready = 1'b0;
      repeat (4) push(P1, M1, 0);
      in_valid = 1'b0;
      check("pend_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("pend_rst_valid", out_valid, 0);
      check("pend_rst_data", out_data, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      got_q.delete();
      repeat (4) push(M1, M1, 0);
      idle(3);
      check("post_rst_count", got_q.size(), 1);
      check("post_rst_sym", got_q[0], 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
